// File: rtl/rom_reader_pkg.sv
// Shared constants and FSM encoding for the ROM scan reader and its bench ROM.
package rom_reader_pkg;

  localparam int unsigned ROM_AW = 4;
  localparam int unsigned ROM_DW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_reader_if.sv
// ROM read port plus output word stream; master = reader, slave = ROM/consumer side.
interface rom_reader_if
  import rom_reader_pkg::*;
#(
  parameter int unsigned AW = ROM_AW,
  parameter int unsigned DW = ROM_DW
);

  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;

  modport master (
    output mem_read, mem_addr,
    input  mem_dout,
    output out_valid, out_data, out_addr,
    input  out_ready
  );

  modport slave (
    input  mem_read, mem_addr,
    output mem_dout,
    input  out_valid, out_data, out_addr,
    output out_ready
  );

endinterface

// File: rtl/rom_rd_fifo.sv
// Output buffer for captured ROM words: DEPTH entries, push/pop/flush, occupancy count.
module rom_rd_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rptr];

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count == CW'(DEPTH)));

  underflow_check: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count == '0));

endmodule

// File: rtl/rom_reader.sv
// Scans a ROM address range with flow-controlled reads and streams tagged words out in order.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned AW    = ROM_AW,
  parameter int unsigned DW    = ROM_DW,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  rom_reader_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr;
  logic [AW-1:0] rem;
  logic [AW-1:0] tag;
  logic          inflight;
  logic          issue;
  logic          done_nx;
  logic          accept;
  logic          pop;
  logic          push;
  logic          flush;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [AW+DW-1:0] rdata;

  assign accept = (state == ST_IDLE) && start && !abort;
  assign pop    = bus.out_valid && bus.out_ready;
  assign push   = inflight && !abort;
  assign flush  = abort && (state != ST_IDLE);

  // Occupancy counts the word leaving this cycle as already gone, so the
  // next read can be issued alongside an accept and throughput stays 1/cycle.
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else begin
          issue = (occ < (CW+1)'(DEPTH));
          if (issue && rem == '0) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (occ == '0) begin
          state_nx = ST_IDLE;
          done_nx  = pop;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      rem      <= '0;
      tag      <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= done_nx;
      inflight <= issue;
      if (accept) begin
        addr <= first_addr;
        rem  <= last_addr - first_addr;
      end else if (issue) begin
        tag  <= addr;
        addr <= addr + AW'(1);
        rem  <= rem - AW'(1);
      end
    end
  end

  rom_rd_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata ({tag, bus.mem_dout}),
    .pop   (pop),
    .rdata (rdata),
    .count (count)
  );

  assign busy          = (state != ST_IDLE);
  assign bus.mem_read  = issue;
  assign bus.mem_addr  = addr;
  assign bus.out_valid = (count != '0);
  assign bus.out_addr  = rdata[DW +: AW];
  assign bus.out_data  = rdata[DW-1:0];

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: ROM model data = addr ^ 4'hA, scoreboard of expected words.
module tb_rom_reader;
  import rom_reader_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] first_addr = '0;
  logic [3:0] last_addr = '0;
  logic       busy;
  logic       done;
  logic [3:0] rom_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  rom_reader_if #(.AW(ROM_AW), .DW(ROM_DW)) bus ();

  rom_reader #(.AW(ROM_AW), .DW(ROM_DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // ROM: one-cycle latency, data = addr ^ 4'hA
  always @(posedge clk) rom_q <= bus.mem_addr ^ 4'hA;
  assign bus.mem_dout = rom_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: ready held 1, mode 1: ready toggles each cycle, mode 2: random ready
  task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input int mode, input bit poke_start);
    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic [7:0] w;
    logic [3:0] span;
    logic [3:0] a;
    logic [3:0] ea;
    int total, issued, accepted, cyc, last_acc, stalls, occ_after;
    bit hold, got_done, pop, exp_rd;

    span = l - f;
    total = int'(span) + 1;
    for (int i = 0; i < total; i++) begin
      a = f + 4'(i);
      exp_q.push_back({a, a ^ 4'hA});
    end
    issued = 0; accepted = 0; cyc = 0; last_acc = 0; stalls = 0;
    hold = 1'b0; got_done = 1'b0; held = '0;

    @(posedge clk); #1;
    start = 1'b1; first_addr = f; last_addr = l; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; first_addr = 4'($urandom); last_addr = 4'($urandom);

    while (!got_done && cyc < 300) begin
      @(negedge clk);
      pop = bus.out_valid && bus.out_ready;
      if (hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_word", {bus.out_addr, bus.out_data}, held);
      end
      occ_after = issued - accepted - (pop ? 1 : 0);
      exp_rd = (issued < total) && (occ_after < int'(DEPTH));
      if (issued < total && !exp_rd) stalls++;
      chk("mem_read", bus.mem_read, exp_rd);
      if (bus.mem_read) begin
        ea = f + 4'(issued);
        chk("mem_addr", bus.mem_addr, ea);
        issued++;
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("out_word", {bus.out_addr, bus.out_data}, w);
        end
        if (mode == 0) begin
          if (accepted == 0) chk("first_latency", cyc, 2);
          else chk("back_to_back", cyc, last_acc + 1);
        end
        last_acc = cyc;
        accepted++;
      end
      hold = bus.out_valid && !bus.out_ready;
      held = {bus.out_addr, bus.out_data};
      if (done) begin
        got_done = 1'b1;
        chk("done_after_last", cyc, last_acc + 1);
        chk("done_words_left", exp_q.size(), 0);
        chk("busy_at_done", busy, 0);
      end else begin
        chk("busy_in_scan", busy, 1);
      end
      cyc++;
      if (!got_done) begin
        @(posedge clk); #1;
        case (mode)
          0: bus.out_ready = 1'b1;
          1: bus.out_ready = ~bus.out_ready;
          default: bus.out_ready = ($urandom_range(3) != 0);
        endcase
        if (poke_start) begin
          start = (cyc == 3);
          first_addr = 4'd9; last_addr = 4'd9;
        end
      end
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("words_left", exp_q.size(), 0);
    if (mode == 1) chk("stall_seen", stalls > 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic interrupt(input bit use_rst);
    @(posedge clk); #1;
    start = 1'b1; first_addr = 4'd0; last_addr = 4'd15; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (!use_rst) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_read", bus.mem_read, 0);
    end else begin
      rst_n = 1'b0;
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_read", bus.mem_read, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_addr", bus.out_addr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    repeat (6) begin
      @(negedge clk);
      chk("no_done_after_kill", done, 0);
      chk("no_valid_after_kill", bus.out_valid, 0);
    end
    run_scan(4'd2, 4'd3, 0, 1'b0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    #12;
    chk("reset_read", bus.mem_read, 0);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_out_addr", bus.out_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_scan(4'd0, 4'd15, 0, 1'b0);
    run_scan(4'd14, 4'd1, 0, 1'b0);
    run_scan(4'd7, 4'd7, 0, 1'b0);
    run_scan(4'd0, 4'd5, 1, 1'b0);
    interrupt(1'b0);
    interrupt(1'b1);

    // abort and start together in IDLE: no scan begins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; first_addr = 4'd0; last_addr = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_start_busy", busy, 0);
      chk("abort_start_read", bus.mem_read, 0);
    end

    run_scan(4'd0, 4'd15, 2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_scan(4'($urandom), 4'($urandom), 2, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
